// File: rtl/usp_registration_responder_pkg.sv
// Shared types, hash constants and crypto helpers (key-XOR masking, hash192)
// for the USP registration responder.
package usp_registration_responder_pkg;

    typedef logic [63:0] word_t;

    typedef enum logic [1:0] {
        ST_OK    = 2'd0,
        ST_STALE = 2'd1,
        ST_DUP   = 2'd2,
        ST_FULL  = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_HASH,
        S_SEND,
        S_REPORT
    } state_e;

    localparam word_t HASH_IV = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam word_t HASH_RK = 64'hC3C3_C3C3_C3C3_C3C3;

    function automatic logic [255:0] key_xor256(logic [255:0] d, word_t k);
        return d ^ {4{k}};
    endfunction

    function automatic logic [191:0] key_xor192(logic [191:0] d, word_t k);
        return d ^ {3{k}};
    endfunction

    // One compression round; the shifts act on the pre-round state.
    function automatic word_t hash_round(word_t s, word_t chunk, logic [1:0] i);
        return (s ^ chunk) ^ ((s << 3) ^ (s >> 5)) ^ (HASH_RK >> (9 * int'(i)));
    endfunction

    function automatic word_t hash192(logic [255:0] data);
        word_t s;
        s = HASH_IV;
        for (int i = 0; i < 4; i++) begin
            s = hash_round(s, data[i*64 +: 64], 2'(i));
        end
        return s;
    endfunction

endpackage

// File: rtl/usp_registration_responder_if.sv
// EV <-> USP registration message channels (M1 request, M2 response).
interface usp_registration_responder_if;
    import usp_registration_responder_pkg::*;

    // Both channels: a transfer happens on a clock edge where valid && ready;
    // the sender holds valid and its payload stable until that edge.
    logic         m1_valid;
    logic         m1_ready;
    logic [255:0] M1;
    word_t        T1_ev_in;
    word_t        common_key;
    logic         m2_valid;
    logic         m2_ready;
    logic [191:0] M2;

    modport master (
        output m1_valid, M1, T1_ev_in, common_key, m2_ready,
        input  m1_ready, m2_valid, M2
    );

    modport slave (
        input  m1_valid, M1, T1_ev_in, common_key, m2_ready,
        output m1_ready, m2_valid, M2
    );

endinterface

// File: rtl/usp_registration_responder_hash192_iter.sv
// hash192_iter: iterative hash192, one round per cycle. done is high in the
// cycle whose clock edge applies the last round; digest is final after it.
module hash192_iter
    import usp_registration_responder_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] data,
    output logic         done,
    output word_t        digest
);
    word_t [3:0] chunk_q;
    word_t       s_q;
    logic [1:0]  rnd_q;
    logic        busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chunk_q <= '0;
            s_q     <= '0;
            rnd_q   <= '0;
            busy_q  <= 1'b0;
        end else if (start) begin
            chunk_q <= data;
            s_q     <= HASH_IV;
            rnd_q   <= '0;
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            s_q   <= hash_round(s_q, chunk_q[rnd_q], rnd_q);
            rnd_q <= rnd_q + 2'd1;
            if (rnd_q == 2'd3) busy_q <= 1'b0;
        end
    end

    assign done   = busy_q && (rnd_q == 2'd3);
    assign digest = s_q;

endmodule

// File: rtl/usp_registration_responder.sv
// USP-side registration responder: freshness check, psid table, Aj token, masked M2.
// Replay rejection against the table is enabled by defining USP_REPLAY_CHECK_EN.
module usp_registration_responder
    import usp_registration_responder_pkg::*;
#(
    parameter int  DEPTH            = 4,
    parameter int  ACCEPTABLE_DELAY = 10,
    localparam int CW               = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  word_t                       usp_id_j,
    input  word_t                       usp_pub_key_j,
    usp_registration_responder_if.slave bus,
    output logic                        reg_done,
    output logic [1:0]                  reg_status,
    output logic [CW-1:0]               reg_count,
    output word_t                       usp_time,
    output state_e                      dbg_state
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state_q, state_d;
    logic [191:0]      m1_q;
    word_t             t1_q, key_q, t_now_q, id_q, pub_q, usp_time_q;
    status_e           status_q, chk_status;
    logic [DEPTH-1:0]  tbl_valid_q;
    word_t [DEPTH-1:0] tbl_psid_q;
    logic [CW-1:0]     count_q;
    logic [191:0]      d;
    word_t             psid, ch, rs, aj;
    logic              stale, dup, full, free_found;
    logic [IW-1:0]     free_idx;
    logic              hash_start, hash_done, m1_fire, m2_fire;
    logic              unused_ev_pub;

    // The EV public key word is not needed on this side.
    assign unused_ev_pub = ^bus.M1[63:0];

    assign d    = key_xor192(m1_q, key_q);
    assign psid = d[191:128];
    assign ch   = d[127:64];
    assign rs   = d[63:0];

    // Modular difference: a T1 in the future wraps to a huge value and is stale.
    assign stale = (t_now_q - t1_q) > word_t'(ACCEPTABLE_DELAY);

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!tbl_valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end
    assign full = !free_found;

`ifdef USP_REPLAY_CHECK_EN
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tbl_valid_q[i] && (tbl_psid_q[i] == psid)) dup = 1'b1;
        end
    end
`else
    logic unused_tbl_psid;
    assign dup             = 1'b0;
    assign unused_tbl_psid = ^tbl_psid_q;
`endif

    always_comb begin
        chk_status = ST_OK;
        if (stale)     chk_status = ST_STALE;
        else if (dup)  chk_status = ST_DUP;
        else if (full) chk_status = ST_FULL;
    end

    assign m1_fire = bus.m1_valid && bus.m1_ready;
    assign m2_fire = bus.m2_valid && bus.m2_ready;

    always_comb begin
        state_d    = state_q;
        hash_start = 1'b0;
        case (state_q)
            S_IDLE:   if (m1_fire) state_d = S_CHECK;
            S_CHECK: begin
                if (chk_status != ST_OK) begin
                    state_d = S_REPORT;
                end else begin
                    state_d    = S_HASH;
                    hash_start = 1'b1;
                end
            end
            S_HASH:   if (hash_done) state_d = S_SEND;
            S_SEND:   if (m2_fire) state_d = S_REPORT;
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            usp_time_q  <= '0;
            m1_q        <= '0;
            t1_q        <= '0;
            key_q       <= '0;
            t_now_q     <= '0;
            id_q        <= '0;
            pub_q       <= '0;
            status_q    <= ST_OK;
            tbl_valid_q <= '0;
            tbl_psid_q  <= '0;
            count_q     <= '0;
        end else begin
            usp_time_q <= usp_time_q + 64'd1;
            if (m1_fire) begin
                m1_q    <= bus.M1[255:64];
                t1_q    <= bus.T1_ev_in;
                key_q   <= bus.common_key;
                t_now_q <= usp_time_q;
                id_q    <= usp_id_j;
                pub_q   <= usp_pub_key_j;
            end
            if (state_q == S_CHECK) status_q <= chk_status;
            // A free slot is guaranteed: CHECK rejected the request otherwise.
            if (m2_fire) begin
                tbl_valid_q[free_idx] <= 1'b1;
                tbl_psid_q[free_idx]  <= psid;
                count_q               <= count_q + CW'(1);
            end
        end
    end

    hash192_iter u_hash (
        .clk    (clk),
        .rst    (rst),
        .start  (hash_start),
        .data   ({psid, ch ^ rs, id_q, pub_q}),
        .done   (hash_done),
        .digest (aj)
    );

    assign bus.m1_ready = (state_q == S_IDLE) && !rst;
    assign bus.m2_valid = (state_q == S_SEND);
    assign bus.M2       = (state_q == S_SEND) ? key_xor192({aj, id_q, pub_q}, key_q) : '0;
    assign reg_done     = (state_q == S_REPORT);
    assign reg_status   = status_q;
    assign reg_count    = count_q;
    assign usp_time     = usp_time_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_usp_registration_responder.sv
// Self-checking bench for usp_registration_responder: scenario tasks with a
// scoreboard of expected M2 words and statuses.
module tb_usp_registration_responder;
    import usp_registration_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] usp_id_j;
    logic [63:0] usp_pub_key_j;
    logic        reg_done;
    logic [1:0]  reg_status;
    logic [2:0]  reg_count;
    logic [63:0] usp_time;
    state_e      dbg_state;

    usp_registration_responder_if bus ();

    usp_registration_responder #(.DEPTH(4), .ACCEPTABLE_DELAY(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .usp_id_j      (usp_id_j),
        .usp_pub_key_j (usp_pub_key_j),
        .bus           (bus),
        .reg_done      (reg_done),
        .reg_status    (reg_status),
        .reg_count     (reg_count),
        .usp_time      (usp_time),
        .dbg_state     (dbg_state)
    );

    // Clock / reset-domain timekeeping
    always #5 clk = ~clk;

    logic [63:0] my_time = 64'd0;
    always @(posedge clk) my_time <= rst ? 64'd0 : my_time + 64'd1;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_cnt = 0;
    logic [191:0] exp_m2_q[$];
    logic [1:0]   exp_st_q[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference model of the token and response
    function automatic logic [63:0] ref_hash(logic [63:0] psid, ch, rs, id, pub);
        logic [63:0] w[4];
        logic [63:0] s, rk;
        w[0] = pub;
        w[1] = id;
        w[2] = ch ^ rs;
        w[3] = psid;
        s = 64'hA5A5A5A5A5A5A5A5;
        for (int i = 0; i < 4; i++) begin
            rk = 64'hC3C3C3C3C3C3C3C3 >> (9 * i);
            s  = (s ^ w[i]) ^ ((s << 3) ^ (s >> 5)) ^ rk;
        end
        return s;
    endfunction

    function automatic logic [191:0] ref_m2(logic [63:0] psid, ch, rs, key);
        return {ref_hash(psid, ch, rs, usp_id_j, usp_pub_key_j), usp_id_j, usp_pub_key_j}
               ^ {key, key, key};
    endfunction

    // Driver tasks
    task automatic do_reset();
        rst = 1'b1;
        bus.m1_valid = 1'b0;
        bus.m2_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_cnt = 0;
        exp_m2_q.delete();
        exp_st_q.delete();
    endtask

    task automatic wait_time(input logic [63:0] target);
        for (int i = 0; i < 500 && my_time != target; i++) @(negedge clk);
        n_tests++;
        if (my_time != target || usp_time !== target) begin
            n_fail++;
            $display("FAIL wait_time: usp_time=%0d model=%0d required %0d", usp_time, my_time, target);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge it is idle again.
    task automatic run_req(input logic [63:0] psid, ch, rs, t1, key,
                           input logic [1:0] exp_st, input int hold);
        int           k_seen;
        logic [191:0] exp_m2;
        logic [1:0]   exp_s;
        bus.M1         = {psid, ch, rs, 64'(($urandom() << 32) | $urandom())} ^ {4{key}};
        bus.T1_ev_in   = t1;
        bus.common_key = key;
        bus.m1_valid   = 1'b1;
        bus.m2_ready   = 1'b0;
        n_tests++;
        if (bus.m1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL m1_ready_idle: got %b required 1", bus.m1_ready);
        end
        if (exp_st == 2'd0) begin
            exp_m2_q.push_back(ref_m2(psid, ch, rs, key));
            exp_cnt++;
        end
        exp_st_q.push_back(exp_st);
        @(negedge clk);
        bus.m1_valid = 1'b0;
        k_seen = 0;
        for (int k = 1; k <= 12; k++) begin
            if (bus.m2_valid === 1'b1 || reg_done === 1'b1) begin
                k_seen = k;
                break;
            end
            @(negedge clk);
        end
        n_tests++;
        if (k_seen == 0) begin
            n_fail++;
            $display("FAIL response_timeout: no m2_valid/reg_done within 12 cycles, status %0d required", exp_st);
            if (exp_st == 2'd0) void'(exp_m2_q.pop_front());
            void'(exp_st_q.pop_front());
            return;
        end
        if (exp_st == 2'd0) begin
            if (k_seen != 6 || bus.m2_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL m2_latency: first event at N+%0d m2_valid=%b required N+6 m2_valid=1", k_seen, bus.m2_valid);
            end
            exp_m2 = exp_m2_q.pop_front();
            n_tests++;
            if (bus.M2 !== exp_m2) begin
                n_fail++;
                $display("FAIL m2_value: got %h required %h", bus.M2, exp_m2);
            end
            for (int h = 0; h < hold; h++) begin
                bus.m1_valid = 1'b1;
                @(negedge clk);
                n_tests++;
                if (bus.M2 !== exp_m2 || bus.m2_valid !== 1'b1 || bus.m1_ready !== 1'b0 || reg_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL backpressure_hold: M2=%h m2_valid=%b m1_ready=%b reg_done=%b required %h 1 0 0",
                             bus.M2, bus.m2_valid, bus.m1_ready, reg_done, exp_m2);
                end
            end
            bus.m1_valid = 1'b0;
            bus.m2_ready = 1'b1;
            @(negedge clk);
            bus.m2_ready = 1'b0;
        end else begin
            if (k_seen != 2 || reg_done !== 1'b1 || bus.m2_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reject_latency: first event at N+%0d reg_done=%b m2_valid=%b required N+2 1 0",
                         k_seen, reg_done, bus.m2_valid);
            end
        end
        exp_s = exp_st_q.pop_front();
        n_tests++;
        if (reg_done !== 1'b1 || reg_status !== exp_s) begin
            n_fail++;
            $display("FAIL reg_status: reg_done=%b status=%0d required 1 %0d", reg_done, reg_status, exp_s);
        end
        @(negedge clk);
        n_tests++;
        if (bus.m1_ready !== 1'b1 || reg_done !== 1'b0 || dbg_state !== S_IDLE || reg_count !== 3'(exp_cnt)) begin
            n_fail++;
            $display("FAIL post_request: m1_ready=%b reg_done=%b state=%0d reg_count=%0d required 1 0 %0d %0d",
                     bus.m1_ready, reg_done, dbg_state, reg_count, S_IDLE, exp_cnt);
        end
    endtask

    // Scenarios
    task automatic test_reset();
        bus.m1_valid = 1'b0;
        bus.m2_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.m1_ready !== 1'b0 || bus.m2_valid !== 1'b0 || bus.M2 !== 192'd0 || reg_done !== 1'b0 ||
            reg_status !== 2'd0 || reg_count !== 3'd0 || usp_time !== 64'd0 || dbg_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL reset_values: m1_ready=%b m2_valid=%b M2=%h reg_done=%b status=%0d count=%0d time=%0d state=%0d",
                     bus.m1_ready, bus.m2_valid, bus.M2, reg_done, reg_status, reg_count, usp_time, dbg_state);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.m1_ready !== 1'b1 || usp_time !== 64'd1) begin
            n_fail++;
            $display("FAIL reset_release: m1_ready=%b usp_time=%0d required 1 1", bus.m1_ready, usp_time);
        end
        exp_cnt = 0;
    endtask

    task automatic test_ok();
        wait_time(64'd105);
        run_req(64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF, 64'h0F0F_F0F0_1234_5678,
                64'd100, 64'h1111_1111_1111_1111, 2'd0, 0);
    endtask

    task automatic test_freshness();
        run_req(64'h0000_0000_0000_0A11, 64'h2222, 64'h3333, my_time - 64'd10,
                64'h7777_0000_1234_0001, 2'd0, 0);
        wait_time(64'd200);
        run_req(64'h0000_0000_0000_0B22, 64'h4444, 64'h5555, 64'd189,
                64'h1111_1111_1111_1111, 2'd1, 0);
        run_req(64'h0000_0000_0000_0C33, 64'h6666, 64'h7777, my_time + 64'd1,
                64'h0BAD_CAFE_0000_0000, 2'd1, 0);
    endtask

    task automatic test_replay();
        do_reset();
        run_req(64'hABCD_0000_0000_0042, 64'h11, 64'h22, my_time - 64'd3, 64'h55AA_55AA_0000_1111, 2'd0, 0);
`ifdef USP_REPLAY_CHECK_EN
        run_req(64'hABCD_0000_0000_0042, 64'h33, 64'h44, my_time - 64'd1, 64'h1357_9BDF_0000_2222, 2'd2, 0);
`else
        run_req(64'hABCD_0000_0000_0042, 64'h33, 64'h44, my_time - 64'd1, 64'h1357_9BDF_0000_2222, 2'd0, 0);
`endif
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_req(64'h5000_0000_0000_0000 + 64'(i), 64'(i * 7), 64'(i * 13 + 1),
                    my_time - 64'($urandom_range(0, 10)), {$urandom(), $urandom()}, 2'd0, 0);
        end
        run_req(64'h6000_0000_0000_0005, 64'h1, 64'h2, my_time + 64'd5, 64'h9999, 2'd1, 0);
        run_req(64'h6000_0000_0000_0006, 64'h3, 64'h4, my_time - 64'd2, 64'h8888, 2'd3, 0);
`ifdef USP_REPLAY_CHECK_EN
        run_req(64'h5000_0000_0000_0000, 64'h5, 64'h6, my_time, 64'h7777, 2'd2, 0);
`endif
    endtask

    task automatic test_backpressure();
        do_reset();
        run_req(64'hBACC_0000_0000_0001, 64'hFACE, 64'hB00C, my_time - 64'd4,
                64'h0F1E_2D3C_4B5A_6978, 2'd0, 3);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            usp_id_j      = {$urandom(), $urandom()};
            usp_pub_key_j = {$urandom(), $urandom()};
            run_req({$urandom(), 32'(i)}, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                    my_time - 64'($urandom_range(0, 10)), {$urandom(), $urandom()}, 2'd0, 0);
        end
    endtask

    task automatic test_reset_mid_hash();
        int bad_cycles;
        do_reset();
        run_req(64'h1234_0000_0000_0001, 64'h10, 64'h20, my_time, 64'h4242, 2'd0, 0);
        bus.M1         = {4{64'h0000_0000_0000_0077}};
        bus.T1_ev_in   = my_time;
        bus.common_key = 64'h0;
        bus.m1_valid   = 1'b1;
        @(negedge clk);
        bus.m1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_cnt = 0;
        n_tests++;
        if (bus.m2_valid !== 1'b0 || reg_count !== 3'd0 || reg_done !== 1'b0 || dbg_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL reset_mid_hash: m2_valid=%b reg_count=%0d reg_done=%b state=%0d required 0 0 0 %0d",
                     bus.m2_valid, reg_count, reg_done, dbg_state, S_IDLE);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.m1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_hash_ready: m1_ready=%b required 1", bus.m1_ready);
        end
        bad_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            if (reg_done !== 1'b0 || bus.m2_valid !== 1'b0) bad_cycles++;
            @(negedge clk);
        end
        n_tests++;
        if (bad_cycles != 0) begin
            n_fail++;
            $display("FAIL reset_mid_hash_quiet: %0d cycles with reg_done/m2_valid required 0", bad_cycles);
        end
    endtask

    initial begin
        usp_id_j       = 64'h0123_4567_89AB_CDEF;
        usp_pub_key_j  = 64'hFEDC_BA98_7654_3210;
        bus.m1_valid   = 1'b0;
        bus.m2_ready   = 1'b0;
        bus.M1         = '0;
        bus.T1_ev_in   = '0;
        bus.common_key = '0;
        test_reset();
        test_ok();
        test_freshness();
        test_replay();
        test_full();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_hash();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/usp_registration_responder.md
# usp_registration_responder

USP-side responder for EV registration: accepts the EV's key-masked M1, checks timestamp freshness, recovers the pseudo-identity, computes the registration token Aj with an iterative hash, and returns masked M2. It records each accepted pseudo-identity in a small table and reports a status per request. It is the counterpart of the EV-side registration initiator and uses the shared crypto utility functions (hash192, key-XOR).

## Interface
- DEPTH, 4: registration table entries.
- ACCEPTABLE_DELAY, 10: maximum accepted `usp_time - T1_ev_in`.

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- usp_id_j  in  64  USP identity
- usp_pub_key_j  in  64  USP public key
- common_key  in  64  shared masking key, sampled at M1 accept
- m1_valid  in  1  M1 offered
- m1_ready  out  1  responder idle, can accept M1
- M1  in  256  masked {psid, ch, rs, ev_pub}, MSW first
- T1_ev_in  in  64  EV send timestamp, qualified by m1_valid
- m2_valid  out  1  M2 available
- m2_ready  in  1  downstream takes M2
- M2  out  192  masked {Aj, usp_id_j, usp_pub_key_j}
- reg_done  out  1  one-cycle pulse, request finished
- reg_status  out  2  0 OK, 1 STALE, 2 DUP, 3 FULL; valid with reg_done
- reg_count  out  $clog2(DEPTH+1)  occupied table entries
- usp_time  out  64  free-running timestamp counter

## Operation
- States: IDLE, CHECK, HASH, SEND, REPORT.
- IDLE: m1_ready=1. On m1_valid&&m1_ready, capture M1, T1_ev_in, common_key, and the current usp_time as t_now. Go to CHECK.
- CHECK: unmask D = M1 ^ {4{common_key}}; psid=D[255:192], ch=D[191:128], rs=D[127:64].
  - Freshness: (t_now - T1) mod 2^64 > ACCEPTABLE_DELAY → STALE. T1 later than t_now wraps large → STALE. Difference equal to the limit is accepted.
  - Priority: STALE > DUP > FULL. Any reject goes to REPORT. Otherwise go to HASH.
- HASH: 4 cycles, one round per cycle over data {psid, ch^rs, usp_id_j, usp_pub_key_j}.
  - Initial state: A5A5A5A5A5A5A5A5.
  - Round i uses chunk = data[i*64+:64] and rk = C3C3C3C3C3C3C3C3 >> (9*i).
  - Update: s = (s^chunk) ^ ((s<<3) ^ (s>>5)) ^ rk. Shifts are logical.
  - Result Aj must be bit-identical to hash192.
- SEND: M2 = {Aj, usp_id_j, usp_pub_key_j} ^ {3{common_key}}. Hold m2_valid=1 and keep M2 stable until m2_ready. On handshake: write psid into a free table slot, increment reg_count, go to REPORT with status OK.
- REPORT: reg_done=1 for one cycle with reg_status. Go to IDLE.
- Table: DEPTH valid+psid entries. Lowest free index is written first. Entries never age out. Only rst clears them.

## Timing
- Reset values: m1_ready=0 during rst, 1 on the first cycle after; m2_valid=0, M2=0, reg_done=0, reg_status=0, reg_count=0, usp_time=0, all table valid bits 0, state IDLE.
- usp_time increments every cycle and wraps at 2^64.
- Accept at edge N. CHECK occupies cycle N+1. HASH occupies N+2..N+5. m2_valid is first high at N+6.
- Reject: reg_done pulses at N+2. No m2_valid.
- OK: reg_done pulses the cycle after the m2 handshake. Minimum request-to-request spacing is 8 cycles.
- m1_ready=0 in every state except IDLE. m1_valid outside IDLE is ignored.
- A handshake changes the table in the same cycle. The next CHECK sees the updated table.
- rst in any state aborts the request. m2_valid drops on that edge. No reg_done is produced for the aborted request.

## Configuration
- USP_REPLAY_CHECK_EN defined: CHECK compares psid against all valid entries. A match gives DUP.
- Not defined: no compare logic. The same psid may occupy several entries. DUP is never produced. STALE and FULL are unchanged.

## Structure
- Shared package:
  - status enum (OK/STALE/DUP/FULL);
  - state enum;
  - hash constants A5A5A5A5A5A5A5A5 and C3C3C3C3C3C3C3C3;
  - 64-bit word typedef.
- Key-XOR unmasking uses the existing crypto utility functions.
- Sub-module `hash192_iter`: start/done handshake, 256-bit data in, 64-bit digest out, one round per cycle. The responder instantiates one.

## Test plan
- OK path: key=0x1111111111111111, T1=100, accept at usp_time=105 → m2_valid at N+6; M2^{3{key}} top word = hash192({psid, ch^rs, id, pub}); reg_status=0; reg_count=1.
- Freshness boundary: difference 10 → OK. Difference 11 (usp_time=200, T1=189) → reg_done at N+2 with status 1, no M2, reg_count unchanged. T1=usp_time+1 → STALE.
- Replay (macro defined): same psid sent twice → second returns DUP. Without the macro, both return OK and reg_count=2.
- Full: DEPTH=4, five distinct psids → fifth returns FULL. A stale fifth request returns STALE instead (priority).
- Backpressure: hold m2_ready=0 for 3 cycles → M2 stable, m1_ready=0, m1_valid ignored; handshake on cycle 4 → reg_done on the next cycle.
- Reset mid-HASH: assert rst at N+3 → next cycle m2_valid=0, reg_count=0, m1_ready=1 after release, no reg_done.
